serial_adder_ctrl: RTL and testbench

- Bit-serial N-bit adder controller that reuses one shared 1-bit full-add cell, built from two half_adder instances plus an OR gate, for WIDTH cycles per operation.
- Accepts operands over a valid/ready input handshake, sequences the add LSB-first and returns the sum and carry over a valid/ready output handshake.
- Sits between operand producers and the result consumer wherever area matters more than latency.

---
 rtl/serial_adder_ctrl.sv | 132 +++++++++++++
 tb/tb_serial_adder_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder reusing one full-add cell (two half adders + OR), LSB first.
// Optional subtract mode enabled by defining SERIAL_SUB_EN (adds the 'sub' input port).

module half_adder (
  input  logic a_i,
  input  logic b_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i;
  assign c_o = a_i & b_i;
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
`ifdef SERIAL_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  // state | meaning
  // IDLE  | waiting for operands, in_ready high
  // RUN   | one bit per cycle through the shared full-add cell
  // DONE  | result held until the consumer takes it
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic             in_ready_q, out_valid_q, busy_q;
  logic [WIDTH-1:0] a_sh_q, b_sh_q, sum_q;
  logic [WIDTH-1:0] a_sh_d, b_sh_d, sum_d;
  logic             carry_q, carry_d, carry_out_q;
  logic [CW-1:0]    cnt_q;
  logic             s1, c1, c2, bit_res;
  logic [WIDTH-1:0] b_load;
  logic             c_load;

  half_adder u_ha1 (.a_i(a_sh_q[0]), .b_i(b_sh_q[0]), .s_o(s1),      .c_o(c1));
  half_adder u_ha2 (.a_i(s1),        .b_i(carry_q),   .s_o(bit_res), .c_o(c2));

  assign carry_d = c1 | c2;
  assign a_sh_d  = a_sh_q >> 1;
  assign b_sh_d  = b_sh_q >> 1;

  generate
    if (WIDTH == 1) begin : g_sum_w1
      assign sum_d = bit_res;
    end else begin : g_sum_wn
      assign sum_d = {bit_res, sum_q[WIDTH-1:1]};
    end
  endgenerate

`ifdef SERIAL_SUB_EN
  // Two's-complement subtract: invert B and inject a carry-in of one.
  assign b_load = sub ? ~op_b : op_b;
  assign c_load = sub;
`else
  assign b_load = op_b;
  assign c_load = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      carry_out_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_sh_q     <= op_a;
            b_sh_q     <= b_load;
            carry_q    <= c_load;
            cnt_q      <= '0;
            state_q    <= RUN;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        RUN: begin
          sum_q   <= sum_d;
          a_sh_q  <= a_sh_d;
          b_sh_q  <= b_sh_d;
          carry_q <= carry_d;
          cnt_q   <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            carry_out_q <= carry_d;
            state_q     <= DONE;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign sum       = sum_q;
  assign carry_out = carry_out_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8): directed cases plus randomized traffic.
// Define SERIAL_SUB_EN to also exercise subtract mode.

module tb_serial_adder_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         sub_v = 1'b0;
  logic         in_ready, out_valid, carry_out, busy;
  logic [W-1:0] sum;

  int checks = 0;
  int errors = 0;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b),
`ifdef SERIAL_SUB_EN
    .sub(sub_v),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .carry_out(carry_out), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // {carry, sum} as plain arithmetic; subtract is a + ~b + 1
  function automatic logic [W:0] calc(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    if (s) return {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
    return {1'b0, a} + {1'b0, b};
  endfunction

  // Behavioural timeline: accept -> W busy cycles -> result offered until taken.
  typedef enum {M_IDLE, M_RUN, M_DONE} mph_t;
  mph_t         m_ph = M_IDLE;
  int           m_left = 0;
  logic [W:0]   m_res = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ph = M_IDLE; m_left = 0; m_res = '0;
    end else begin
      case (m_ph)
        M_IDLE: if (in_valid) begin
          m_res = calc(op_a, op_b, sub_v); m_left = W; m_ph = M_RUN;
        end
        M_RUN: begin
          m_left--;
          if (m_left == 0) m_ph = M_DONE;
        end
        default: if (out_ready) m_ph = M_IDLE;
      endcase
    end
  end

  always @(posedge clk) begin
    #2;
    if (rst_n) begin
      chk("model in_ready", in_ready, m_ph == M_IDLE);
      chk("model busy", busy, m_ph == M_RUN);
      chk("model out_valid", out_valid, m_ph == M_DONE);
      if (m_ph == M_DONE) begin
        chk("model sum", sum, m_res[W-1:0]);
        chk("model carry_out", carry_out, m_res[W]);
      end
    end
  end

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       input logic [W-1:0] es, input logic ec, input string nm);
    int n;
    @(negedge clk);
    in_valid = 1'b1; op_a = a; op_b = b; sub_v = s; out_ready = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    chk({nm, " accept"}, in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 50) begin @(negedge clk); n++; end
    chk({nm, " latency"}, n, W);
    chk({nm, " sum"}, sum, es);
    chk({nm, " carry"}, carry_out, ec);
    @(negedge clk);
    chk({nm, " in_ready after"}, in_ready, 1'b1);
    chk({nm, " out_valid drop"}, out_valid, 1'b0);
  endtask

  logic [W:0] exp_q[$];
  logic [W:0] e;
  logic [W-1:0] got_s[2];
  logic         got_c[2];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not end, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, acc, got;
    logic pend;
    #12;
    chk("reset in_ready", in_ready, 1'b1);
    chk("reset out_valid", out_valid, 1'b0);
    chk("reset busy", busy, 1'b0);
    chk("reset sum", sum, 8'h00);
    chk("reset carry", carry_out, 1'b0);
    @(negedge clk); rst_n = 1'b1;

    do_op(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, "00+00");
    do_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "FF+01");
    do_op(8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0, "A5+5A");
    do_op(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, "80+80");

    // Backpressure with an ignored second request
    @(negedge clk);
    in_valid = 1'b1; op_a = 8'h3C; op_b = 8'h0F; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 50) begin @(negedge clk); n++; end
    in_valid = 1'b1; op_a = 8'h11; op_b = 8'h22;
    for (int i = 0; i < 5; i++) begin
      chk("bp out_valid", out_valid, 1'b1);
      chk("bp sum", sum, 8'h4B);
      chk("bp in_ready", in_ready, 1'b0);
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("bp release in_ready", in_ready, 1'b1);
    chk("bp release out_valid", out_valid, 1'b0);
    @(negedge clk);
    chk("bp second not captured", busy, 1'b0);

    // Reset mid-RUN
    in_valid = 1'b1; op_a = 8'h12; op_b = 8'h34;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort in_ready", in_ready, 1'b1);
    chk("abort busy", busy, 1'b0);
    chk("abort out_valid", out_valid, 1'b0);
    chk("abort sum", sum, 8'h00);
    chk("abort carry", carry_out, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid) n++;
    end
    chk("abort no out_valid", n, 0);
    do_op(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, "01+02");

    // Back-to-back with in_valid held high
    @(negedge clk);
    in_valid = 1'b1; op_a = 8'h10; op_b = 8'h20; out_ready = 1'b1;
    acc = 0; got = 0;
    for (int i = 0; i < 100 && got < 2; i++) begin
      pend = in_valid && in_ready;
      if (out_valid && out_ready) begin
        got_s[got] = sum; got_c[got] = carry_out; got++;
      end
      @(negedge clk);
      if (pend) begin
        acc++;
        if (acc == 1) begin op_a = 8'h7F; op_b = 8'h01; end
        else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    chk("b2b count", got, 2);
    chk("b2b first sum", got_s[0], 8'h30);
    chk("b2b first carry", got_c[0], 1'b0);
    chk("b2b second sum", got_s[1], 8'h80);
    chk("b2b second carry", got_c[1], 1'b0);

`ifdef SERIAL_SUB_EN
    do_op(8'h10, 8'h01, 1'b1, 8'h0F, 1'b1, "10-01");
    do_op(8'h01, 8'h02, 1'b1, 8'hFF, 1'b0, "01-02");
`endif

    // Randomized traffic with an in-order scoreboard
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      in_valid  = $urandom_range(0, 1);
      op_a      = W'($urandom);
      op_b      = W'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
`ifdef SERIAL_SUB_EN
      sub_v     = $urandom_range(0, 1);
`endif
      if (in_valid && in_ready) exp_q.push_back(calc(op_a, op_b, sub_v));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("rand unexpected result", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("rand sum", sum, e[W-1:0]);
          chk("rand carry", carry_out, e[W]);
        end
      end
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (out_valid) begin
        if (exp_q.size() == 0) chk("drain unexpected result", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("drain sum", sum, e[W-1:0]);
          chk("drain carry", carry_out, e[W]);
        end
      end
      @(negedge clk);
    end
    chk("scoreboard empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
